mdu_unit: RTL and testbench
===========================

# mdu_unit

Multi-cycle multiply/divide unit with HI/LO registers. It sits alongside the ALU in the execute stage of the pipelined MIPS core: it consumes the same rs/rt operand values as the ALU and feeds HI/LO back to the register-write mux for MFHI/MFLO. It exposes a busy flag, which the hazard controller uses to stall any following MDU instruction.

## Interface
- MULT_CYCLES, default 5: busy duration for MULT/MULTU; legal range 1-31.
- DIV_CYCLES, default 10: busy duration for DIV/DIVU; legal range 1-31.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low; asserted when 0.
- start  in  1  launch strobe for mdu_op; sampled on rising clk.
- mdu_op  in  3  operation code (see Operation).
- A  in  32  operand A (rs value).
- B  in  32  operand B (rt value).
- busy  out  1  multi-cycle operation in progress.
- hi  out  32  HI register.
- lo  out  32  LO register.

## Operation
- mdu_op encoding:
  - 0 NONE
  - 1 MULT
  - 2 MULTU
  - 3 DIV
  - 4 DIVU
  - 5 MTHI
  - 6 MTLO
  - 7 reserved, treated as NONE.
- States:
  - IDLE (busy=0).
  - RUN (busy=1, 5-bit down-counter cnt).
- IDLE, start=1, op MULT/MULTU/DIV/DIVU:
  - latch A, B and op;
  - load cnt with MULT_CYCLES or DIV_CYCLES;
  - go to RUN.
- IDLE, start=1, op MTHI: hi <= A at that edge; stay IDLE. MTLO: lo <= A likewise.
- IDLE, start=1, op NONE/7: no effect.
- RUN: cnt decrements each edge. On the edge where cnt==1:
  - hi/lo take the computed result;
  - go to IDLE.
- start while busy=1 is ignored; no state change, no queueing. The hazard controller must stall.
- hi and lo hold their values while RUN. Intermediate results are never visible.
- MULT: {hi,lo} = signed 64-bit product of latched A×B. MULTU: same, unsigned.
- DIV: lo = signed quotient, truncated toward zero; hi = remainder, with the sign of the dividend.
- DIVU: unsigned quotient and remainder.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Division by zero (B==0):
  - busy still asserted for DIV_CYCLES;
  - hi and lo are left unchanged at completion.
- Results are computed from the latched operands only. A/B changing during RUN has no effect.

## Timing
- Reset (reset=0), effective immediately and independent of clk:
  - busy=0, hi=0, lo=0, cnt=0;
  - state goes to IDLE.
- Reset mid-operation aborts the operation; no result is written.
- start accepted at edge t, op MULT/MULTU:
  - busy=1 after edge t;
  - busy=0 after edge t+MULT_CYCLES;
  - hi/lo new values visible after edge t+MULT_CYCLES.
- start accepted at edge t, op DIV/DIVU: same timing with DIV_CYCLES.
- Back-to-back launch: a new operation may be accepted at edge t+N, the same edge where the previous one completes only if busy was already 0 before that edge. In practice the earliest next accept is edge t+N+1.
- MTHI/MTLO: zero latency; value visible after the accepting edge.
- busy, hi and lo are register outputs; no combinational path from inputs to outputs.

## Structure
- Shared package mdu_pkg contains:
  - the mdu_op localparams (MDU_NONE … MDU_MTLO);
  - the 3-bit op width constant.
  The decoder (controller) imports the same package.
- Single module. Product and quotient are formed combinationally from the latched operands using Verilog `*`, `/` and `%`, with $signed for the signed ops. The cycle count is a behavioural model of a multi-cycle datapath; no divider sub-module.
- State is a single bit (busy); the counter is 5 bits wide.

## Test plan
- Reset check:
  - Stimulus: assert reset=0 mid-DIV run (cnt=4).
  - Required: busy=0, hi=0, lo=0 immediately; after release, no result ever appears.
- MULT latency:
  - Stimulus: MULT with A=0xFFFFFFFE (-2), B=3, default parameters.
  - Required: busy high for exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
  - Stimulus: MULTU with the same operands.
  - Required: hi=0x00000002, lo=0xFFFFFFFA.
- DIV signs:
  - Stimulus: DIV with A=-7, B=2.
  - Required: busy high for 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - Stimulus: DIVU with A=7, B=2.
  - Required: lo=3, hi=1.
- Divide by zero:
  - Stimulus: MTHI 0x1234, then MTLO 0x5678, then DIV with B=0.
  - Required: busy high for 10 cycles; hi=0x1234, lo=0x5678 unchanged afterwards.
- Busy interlock:
  - Stimulus: during a MULT, pulse start with MTLO A=0xDEAD and with DIV.
  - Required: both are ignored; only the MULT result lands; busy timing is unchanged.
- Operand isolation:
  - Stimulus: change A and B every cycle during a DIVU 100/7 run.
  - Required: lo=14, hi=2.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit and the decoder that drives it.
// Operation codes, their width, and a helper classifying multi-cycle operations.
package mdu_pkg;

  localparam int MDU_OP_W = 3;

  localparam logic [MDU_OP_W-1:0] MDU_NONE  = 3'd0;
  localparam logic [MDU_OP_W-1:0] MDU_MULT  = 3'd1;
  localparam logic [MDU_OP_W-1:0] MDU_MULTU = 3'd2;
  localparam logic [MDU_OP_W-1:0] MDU_DIV   = 3'd3;
  localparam logic [MDU_OP_W-1:0] MDU_DIVU  = 3'd4;
  localparam logic [MDU_OP_W-1:0] MDU_MTHI  = 3'd5;
  localparam logic [MDU_OP_W-1:0] MDU_MTLO  = 3'd6;

  // True for operations that occupy the unit for several cycles.
  function automatic logic is_long_op(input logic [MDU_OP_W-1:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) ||
           (op == MDU_DIV)  || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the execute stage.
// The result is formed from latched operands and committed on the last busy cycle.
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [MDU_OP_W-1:0] mdu_op,
  input  logic [31:0]         A,
  input  logic [31:0]         B,
  output logic                busy,
  output logic [31:0]         hi,
  output logic [31:0]         lo
);

  localparam logic [4:0] MULT_CNT = 5'(MULT_CYCLES);
  localparam logic [4:0] DIV_CNT  = 5'(DIV_CYCLES);

  // Handshake: start is a one-cycle request sampled on the rising edge; it is
  // accepted only when busy is 0, and a request seen while busy=1 is dropped
  // (the hazard controller stalls instead of relying on queueing).
  logic                busy_q, busy_d;
  logic [4:0]          cnt_q, cnt_d;
  logic [MDU_OP_W-1:0] op_q, op_d;
  logic [31:0]         a_q, a_d;
  logic [31:0]         b_q, b_d;
  logic [31:0]         hi_q, hi_d;
  logic [31:0]         lo_q, lo_d;

  logic signed [63:0]  smul;
  logic [63:0]         umul;
  logic                res_we;
  logic [31:0]         res_hi;
  logic [31:0]         res_lo;

  assign smul = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
  assign umul = {32'd0, a_q} * {32'd0, b_q};

  always_comb begin
    res_we = 1'b0;
    res_hi = hi_q;
    res_lo = lo_q;
    case (op_q)
      MDU_MULT: begin
        res_we = 1'b1;
        res_hi = smul[63:32];
        res_lo = smul[31:0];
      end
      MDU_MULTU: begin
        res_we = 1'b1;
        res_hi = umul[63:32];
        res_lo = umul[31:0];
      end
      MDU_DIV: begin
        // A zero divisor leaves HI/LO untouched; the overflow case is pinned explicitly.
        if (b_q != 32'd0) begin
          res_we = 1'b1;
          if ((a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF)) begin
            res_lo = 32'h8000_0000;
            res_hi = 32'd0;
          end else begin
            res_lo = $signed(a_q) / $signed(b_q);
            res_hi = $signed(a_q) % $signed(b_q);
          end
        end
      end
      MDU_DIVU: begin
        if (b_q != 32'd0) begin
          res_we = 1'b1;
          res_lo = a_q / b_q;
          res_hi = a_q % b_q;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    op_d   = op_q;
    a_d    = a_q;
    b_d    = b_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    if (!busy_q) begin
      if (start) begin
        if (is_long_op(mdu_op)) begin
          busy_d = 1'b1;
          op_d   = mdu_op;
          a_d    = A;
          b_d    = B;
          cnt_d  = ((mdu_op == MDU_MULT) || (mdu_op == MDU_MULTU)) ? MULT_CNT : DIV_CNT;
        end else if (mdu_op == MDU_MTHI) begin
          hi_d = A;
        end else if (mdu_op == MDU_MTLO) begin
          lo_d = A;
        end
      end
    end else begin
      cnt_d = cnt_q - 5'd1;
      if (cnt_q == 5'd1) begin
        busy_d = 1'b0;
        if (res_we) begin
          hi_d = res_hi;
          lo_d = res_lo;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q <= 1'b0;
      cnt_q  <= 5'd0;
      op_q   <= MDU_NONE;
      a_q    <= 32'd0;
      b_q    <= 32'd0;
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      op_q   <= op_d;
      a_q    <= a_d;
      b_q    <= b_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: directed cases plus random operations
// compared against an arithmetic reference model of HI/LO and busy duration.
module tb_mdu_unit;
  import mdu_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic                clk;
  logic                reset;
  logic                start;
  logic [MDU_OP_W-1:0] mdu_op;
  logic [31:0]         A;
  logic [31:0]         B;
  logic                busy;
  logic [31:0]         hi;
  logic [31:0]         lo;

  int total = 0;
  int bad   = 0;

  logic [63:0] exp_q[$];
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  mdu_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .mdu_op(mdu_op),
    .A(A), .B(B), .busy(busy), .hi(hi), .lo(lo)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: new {hi,lo} after the operation, straight from the arithmetic rules.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic [31:0] cur_hi, input logic [31:0] cur_lo);
    longint          sp;
    longint unsigned up;
    int              sa;
    int              sb;
    sa = a;
    sb = b;
    case (op)
      MDU_MULT:  begin sp = longint'(sa) * longint'(sb); return sp; end
      MDU_MULTU: begin up = longint'({32'd0, a}) * longint'({32'd0, b}); return up; end
      MDU_DIV: begin
        if (b == 0) return {cur_hi, cur_lo};
        if (a == 32'h8000_0000 && sb == -1) return {32'd0, 32'h8000_0000};
        return {32'(sa % sb), 32'(sa / sb)};
      end
      MDU_DIVU: begin
        if (b == 0) return {cur_hi, cur_lo};
        return {a % b, a / b};
      end
      MDU_MTHI:  return {a, cur_lo};
      MDU_MTLO:  return {cur_hi, a};
      default:   return {cur_hi, cur_lo};
    endcase
  endfunction

  function automatic int op_len(input logic [2:0] op);
    if (op == MDU_MULT || op == MDU_MULTU) return MC;
    if (op == MDU_DIV || op == MDU_DIVU) return DC;
    return 0;
  endfunction

  // Driver: issue one operation and check busy every cycle plus the final HI/LO.
  // scramble: randomize A/B while running; poke: try MTLO then DIV while busy.
  task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input bit scramble, input bit poke);
    int          n;
    logic [63:0] e;
    n = op_len(op);
    exp_q.push_back(model(op, a, b, m_hi, m_lo));
    @(negedge clk);
    start = 1'b1; mdu_op = op; A = a; B = b;
    @(negedge clk);
    start = 1'b0; mdu_op = MDU_NONE;
    if (n > 0) begin
      for (int i = 1; i <= n; i++) begin
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        chk({tag, "_hold"}, {hi, lo}, {m_hi, m_lo});
        if (scramble) begin A = $urandom; B = $urandom; end
        if (poke && i == 1) begin start = 1'b1; mdu_op = MDU_MTLO; A = 32'hDEAD; end
        if (poke && i == 2) begin start = 1'b1; mdu_op = MDU_DIV; end
        if (poke && i == 3) begin start = 1'b0; mdu_op = MDU_NONE; end
        if (i < n) @(negedge clk);
      end
      @(negedge clk);
    end
    e = exp_q.pop_front();
    m_hi = e[63:32];
    m_lo = e[31:0];
    chk({tag, "_idle"}, 64'(busy), 64'd0);
    chk({tag, "_res"}, {hi, lo}, e);
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    reset = 1'b0; start = 1'b0; mdu_op = MDU_NONE; A = 0; B = 0;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    do_op("mult",  MDU_MULT,  32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);
    chk("mult_val", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFA});
    do_op("multu", MDU_MULTU, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);
    chk("multu_val", {hi, lo}, {32'h0000_0002, 32'hFFFF_FFFA});
    do_op("div",   MDU_DIV,   32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    chk("div_val", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    do_op("divu",  MDU_DIVU,  32'd7, 32'd2, 1'b0, 1'b0);
    chk("divu_val", {hi, lo}, {32'd1, 32'd3});
    do_op("ovf",   MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    chk("ovf_val", {hi, lo}, {32'd0, 32'h8000_0000});

    do_op("mthi", MDU_MTHI, 32'h1234, 32'd0, 1'b0, 1'b0);
    do_op("mtlo", MDU_MTLO, 32'h5678, 32'd0, 1'b0, 1'b0);
    do_op("div0", MDU_DIV,  32'd99, 32'd0, 1'b0, 1'b0);
    chk("div0_val", {hi, lo}, {32'h1234, 32'h5678});

    do_op("lock", MDU_MULT, 32'd6, 32'd7, 1'b0, 1'b1);
    chk("lock_val", {hi, lo}, {32'd0, 32'd42});
    do_op("iso", MDU_DIVU, 32'd100, 32'd7, 1'b1, 1'b0);
    chk("iso_val", {hi, lo}, {32'd2, 32'd14});

    // Reset in the middle of a DIV, when four cycles remain.
    @(negedge clk);
    start = 1'b1; mdu_op = MDU_DIV; A = 32'd1000; B = 32'd3;
    @(negedge clk);
    start = 1'b0; mdu_op = MDU_NONE;
    repeat (6) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    m_hi = 0; m_lo = 0;
    repeat (DC + 4) @(negedge clk);
    chk("midrst_after_busy", 64'(busy), 64'd0);
    chk("midrst_after_hilo", {hi, lo}, 64'd0);

    // Random operations, including zero divisors and the signed overflow pair.
    for (int k = 0; k < 60; k++) begin
      rop = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 20));
        default: ;
      endcase
      do_op("rand", rop, ra, rb, bit'($urandom_range(0, 1)), 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
